// File: rtl/axi4_lite_pkg.sv
// Shared types and bus-geometry helpers for the AXI4-Lite register file slave.
// Response codes plus strobe width and byte-offset width derived from the data bus width.
package axi4_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } resp_t;

  function automatic int strb_width(input int data_width);
    return data_width / 8;
  endfunction

  // Number of address bits that select a byte within one data word.
  function automatic int addr_lsb(input int data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi4_lite_addr_decode.sv
// Combinational address decoder: byte address -> register index, range error, read-only flag.
// Byte-offset bits below the word size are ignored.
module axi4_lite_addr_decode
  import axi4_lite_pkg::*;
#(
  parameter int                DATA_WIDTH = 32,
  parameter int                ADDRESS    = 32,
  parameter int                NUM_REGS   = 16,
  parameter logic [NUM_REGS-1:0] RO_MASK  = '0,
  localparam int               IDX_W      = $clog2(NUM_REGS)
) (
  input  logic [ADDRESS-1:0] addr,
  output logic [IDX_W-1:0]   idx,
  output logic               err,
  output logic               ro
);

  localparam int LSB = addr_lsb(DATA_WIDTH);

  logic [ADDRESS-1:0] word;

  // Compare the full word index so high address bits cannot alias into the array.
  assign word = addr >> LSB;
  assign idx  = word[IDX_W-1:0];
  assign err  = (word >= ADDRESS'(NUM_REGS));
  assign ro   = !err && RO_MASK[idx];

endmodule

// File: rtl/axi4_lite_regfile_slave.sv
// AXI4-Lite register file slave: independent AW/W capture, byte-strobed writes, RO mask,
// SLVERR on bad or read-only accesses, full B/R backpressure and a flat contents output.
module axi4_lite_regfile_slave
  import axi4_lite_pkg::*;
#(
  parameter int                    DATA_WIDTH  = 32,
  parameter int                    ADDRESS     = 32,
  parameter int                    NUM_REGS    = 16,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE = '0,
  parameter logic [NUM_REGS-1:0]   RO_MASK     = '0
) (
  input  logic                             ACLK,
  input  logic                             ARESET,
  input  logic [ADDRESS-1:0]               S_AWADDR,
  input  logic                             S_AWVALID,
  output logic                             S_AWREADY,
  input  logic [DATA_WIDTH-1:0]            S_WDATA,
  input  logic [DATA_WIDTH/8-1:0]          S_WSTRB,
  input  logic                             S_WVALID,
  output logic                             S_WREADY,
  output logic [1:0]                       S_BRESP,
  output logic                             S_BVALID,
  input  logic                             S_BREADY,
  input  logic [ADDRESS-1:0]               S_ARADDR,
  input  logic                             S_ARVALID,
  output logic                             S_ARREADY,
  output logic [DATA_WIDTH-1:0]            S_RDATA,
  output logic [1:0]                       S_RRESP,
  output logic                             S_RVALID,
  input  logic                             S_RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0]   regs_out
);

  localparam int STRB_W = strb_width(DATA_WIDTH);
  localparam int IDX_W  = $clog2(NUM_REGS);

  // Handshake rule on every channel: a transfer happens on the rising ACLK edge where
  // VALID and READY are both high; a source holds VALID and its payload until then.

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];

  logic                  aw_full;
  logic                  w_full;
  logic [ADDRESS-1:0]    aw_addr;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  bvalid;
  resp_t                 bresp;

  logic                  rvalid;
  logic [DATA_WIDTH-1:0] rdata;
  resp_t                 rresp;

  logic [IDX_W-1:0]      aw_idx;
  logic                  aw_err;
  logic                  aw_ro;
  logic [IDX_W-1:0]      ar_idx;
  logic                  ar_err;
  logic                  ar_ro_unused;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  commit;
  logic                  wr_en;

  axi4_lite_addr_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDRESS    (ADDRESS),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_aw_decode (
    .addr (aw_addr),
    .idx  (aw_idx),
    .err  (aw_err),
    .ro   (aw_ro)
  );

  // Read-only registers read normally, so the AR-side RO flag has no consumer.
  axi4_lite_addr_decode #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDRESS    (ADDRESS),
    .NUM_REGS   (NUM_REGS),
    .RO_MASK    (RO_MASK)
  ) u_ar_decode (
    .addr (S_ARADDR),
    .idx  (ar_idx),
    .err  (ar_err),
    .ro   (ar_ro_unused)
  );

  assign S_AWREADY = !ARESET && !aw_full && !bvalid;
  assign S_WREADY  = !ARESET && !w_full && !bvalid;
  assign S_ARREADY = !ARESET && !rvalid;

  assign aw_hs  = S_AWVALID && S_AWREADY;
  assign w_hs   = S_WVALID && S_WREADY;
  assign ar_hs  = S_ARVALID && S_ARREADY;
  // Both holders full can only coexist with bvalid low: a commit clears them and
  // no new AW/W is accepted until the response drains.
  assign commit = aw_full && w_full;
  assign wr_en  = commit && !aw_err && !aw_ro;

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      aw_full <= 1'b0;
      w_full  <= 1'b0;
      aw_addr <= '0;
      w_data  <= '0;
      w_strb  <= '0;
      bvalid  <= 1'b0;
      bresp   <= OKAY;
    end else begin
      if (aw_hs) begin
        aw_addr <= S_AWADDR;
        aw_full <= 1'b1;
      end
      if (w_hs) begin
        w_data <= S_WDATA;
        w_strb <= S_WSTRB;
        w_full <= 1'b1;
      end
      if (commit) begin
        aw_full <= 1'b0;
        w_full  <= 1'b0;
        bvalid  <= 1'b1;
        bresp   <= (aw_err || aw_ro) ? SLVERR : OKAY;
      end else if (bvalid && S_BREADY) begin
        bvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= RESET_VALUE;
      end
    end else if (wr_en) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (w_strb[b]) begin
          regs[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
        end
      end
    end
  end

  // A read landing on a commit edge samples the array before the write takes effect.
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      rresp  <= OKAY;
    end else if (ar_hs) begin
      rvalid <= 1'b1;
      if (ar_err) begin
        rdata <= '0;
        rresp <= SLVERR;
      end else begin
        rdata <= regs[ar_idx];
        rresp <= OKAY;
      end
    end else if (rvalid && S_RREADY) begin
      rvalid <= 1'b0;
    end
  end

  assign S_BVALID = bvalid;
  assign S_BRESP  = bresp;
  assign S_RVALID = rvalid;
  assign S_RDATA  = rdata;
  assign S_RRESP  = rresp;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_out[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: tb/tb_axi4_lite_regfile_slave.sv
// Self-checking bench for axi4_lite_regfile_slave: directed scenarios plus a randomized
// mix, all checked against a word-array model of the register file.
module tb_axi4_lite_regfile_slave;

  localparam int DW = 32;
  localparam int AW = 32;
  localparam int NR = 16;
  localparam logic [DW-1:0] RST_VAL = 32'hC0FF_EE00;
  localparam logic [NR-1:0] RO_MASK = 16'h0020;  // register 5 (0x14) is read-only

  logic              clk;
  logic              rst;
  logic [AW-1:0]     S_AWADDR;
  logic              S_AWVALID;
  logic              S_AWREADY;
  logic [DW-1:0]     S_WDATA;
  logic [DW/8-1:0]   S_WSTRB;
  logic              S_WVALID;
  logic              S_WREADY;
  logic [1:0]        S_BRESP;
  logic              S_BVALID;
  logic              S_BREADY;
  logic [AW-1:0]     S_ARADDR;
  logic              S_ARVALID;
  logic              S_ARREADY;
  logic [DW-1:0]     S_RDATA;
  logic [1:0]        S_RRESP;
  logic              S_RVALID;
  logic              S_RREADY;
  logic [NR*DW-1:0]  regs_out;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] model [NR];
  logic [NR-1:0] ro_bits;
  logic [DW-1:0] exp_q [$];

  axi4_lite_regfile_slave #(
    .DATA_WIDTH  (DW),
    .ADDRESS     (AW),
    .NUM_REGS    (NR),
    .RESET_VALUE (RST_VAL),
    .RO_MASK     (RO_MASK)
  ) dut (
    .ACLK      (clk),
    .ARESET    (rst),
    .S_AWADDR  (S_AWADDR),
    .S_AWVALID (S_AWVALID),
    .S_AWREADY (S_AWREADY),
    .S_WDATA   (S_WDATA),
    .S_WSTRB   (S_WSTRB),
    .S_WVALID  (S_WVALID),
    .S_WREADY  (S_WREADY),
    .S_BRESP   (S_BRESP),
    .S_BVALID  (S_BVALID),
    .S_BREADY  (S_BREADY),
    .S_ARADDR  (S_ARADDR),
    .S_ARVALID (S_ARVALID),
    .S_ARREADY (S_ARREADY),
    .S_RDATA   (S_RDATA),
    .S_RRESP   (S_RRESP),
    .S_RVALID  (S_RVALID),
    .S_RREADY  (S_RREADY),
    .regs_out  (regs_out)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // reference model
  function automatic bit m_err(input logic [31:0] a);
    return (a / 4) >= NR;
  endfunction

  function automatic bit m_ro(input logic [31:0] a);
    if (m_err(a)) return 1'b0;
    return ro_bits[a / 4];
  endfunction

  function automatic logic [1:0] m_resp(input logic [31:0] a, input bit is_write);
    if (m_err(a) || (is_write && m_ro(a))) return 2'b10;
    return 2'b00;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NR; i++) model[i] = RST_VAL;
  endfunction

  function automatic void m_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] mask;
    if (m_err(a) || m_ro(a)) return;
    mask = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    model[a / 4] = (model[a / 4] & ~mask) | (d & mask);
  endfunction

  function automatic logic [31:0] m_read(input logic [31:0] a);
    if (m_err(a)) return 32'h0;
    return model[a / 4];
  endfunction

  function automatic logic [NR*DW-1:0] m_flat();
    logic [NR*DW-1:0] v;
    for (int i = 0; i < NR; i++) v[i*DW +: DW] = model[i];
    return v;
  endfunction

  // drivers (called and return on a falling edge)
  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly,
                          output logic [1:0] resp, output int lat, output bit tmo);
    bit aw_done = 0;
    bit w_done  = 0;
    bit aw_now;
    bit w_now;
    int cyc = 0;
    tmo = 0;
    lat = 0;
    resp = 2'bxx;
    S_BREADY = 1'b0;
    while (!(aw_done && w_done) && cyc < 40) begin
      if (!aw_done && cyc >= aw_dly) begin S_AWVALID = 1'b1; S_AWADDR = a; end
      if (!w_done && cyc >= w_dly) begin S_WVALID = 1'b1; S_WDATA = d; S_WSTRB = s; end
      aw_now = S_AWVALID && S_AWREADY;
      w_now  = S_WVALID && S_WREADY;
      @(posedge clk);
      aw_done |= aw_now;
      w_done  |= w_now;
      @(negedge clk);
      if (aw_now) S_AWVALID = 1'b0;
      if (w_now) S_WVALID = 1'b0;
      cyc++;
    end
    if (!(aw_done && w_done)) begin
      S_AWVALID = 1'b0;
      S_WVALID  = 1'b0;
      tmo = 1;
      return;
    end
    while (!S_BVALID && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    if (!S_BVALID) begin
      tmo = 1;
      return;
    end
    resp = S_BRESP;
    S_BREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    S_BREADY = 1'b0;
  endtask

  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] resp,
                         output bit tmo);
    int n = 0;
    tmo = 0;
    d = 'x;
    resp = 2'bxx;
    S_ARADDR  = a;
    S_ARVALID = 1'b1;
    S_RREADY  = 1'b0;
    while (!S_ARREADY && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!S_ARREADY) begin
      S_ARVALID = 1'b0;
      tmo = 1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    S_ARVALID = 1'b0;
    if (!S_RVALID) begin
      tmo = 1;
      return;
    end
    d = S_RDATA;
    resp = S_RRESP;
    S_RREADY = 1'b1;
    @(posedge clk);
    @(negedge clk);
    S_RREADY = 1'b0;
  endtask

  // scenarios
  task automatic test_reset();
    logic [31:0] d;
    logic [1:0]  r;
    bit          tmo;
    rst = 1'b1;
    S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0; S_BREADY = 0; S_RREADY = 0;
    S_AWADDR = '0; S_WDATA = '0; S_WSTRB = '0; S_ARADDR = '0;
    m_reset();
    repeat (3) @(negedge clk);
    total++;
    if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b000) begin
      bad++; $display("FAIL reset_readys: got %b want 000", {S_AWREADY, S_WREADY, S_ARREADY});
    end
    total++;
    if ({S_BVALID, S_RVALID, S_BRESP, S_RRESP} !== 6'b0) begin
      bad++; $display("FAIL reset_resp: got bv=%b rv=%b bresp=%b rresp=%b", S_BVALID, S_RVALID, S_BRESP, S_RRESP);
    end
    total++;
    if (S_RDATA !== 32'h0) begin bad++; $display("FAIL reset_rdata: got %h want 0", S_RDATA); end
    total++;
    if (regs_out !== m_flat()) begin bad++; $display("FAIL reset_regs: got %h want %h", regs_out, m_flat()); end
    rst = 1'b0;
    @(negedge clk);
    total++;
    if ({S_AWREADY, S_WREADY, S_ARREADY} !== 3'b111) begin
      bad++; $display("FAIL post_reset_readys: got %b want 111", {S_AWREADY, S_WREADY, S_ARREADY});
    end
    do_read(32'h0, d, r, tmo);
    total++;
    if (tmo || d !== m_read(32'h0) || r !== 2'b00) begin
      bad++; $display("FAIL reset_read_0: got %h/%b tmo=%0d want %h/00", d, r, tmo, m_read(32'h0));
    end
    do_read(32'h3C, d, r, tmo);
    total++;
    if (tmo || d !== RST_VAL || r !== 2'b00) begin
      bad++; $display("FAIL reset_read_3c: got %h/%b tmo=%0d want %h/00", d, r, tmo, RST_VAL);
    end
  endtask

  task automatic test_same_cycle();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bit          tmo;
    do_write(32'h04, 32'hDEADBEEF, 4'hF, 0, 0, r, lat, tmo);
    m_write(32'h04, 32'hDEADBEEF, 4'hF);
    total++;
    if (tmo || lat != 1 || r !== 2'b00) begin
      bad++; $display("FAIL same_cycle_b: got lat=%0d resp=%b tmo=%0d want lat=1 resp=00", lat, r, tmo);
    end
    total++;
    if (S_BVALID !== 1'b0) begin bad++; $display("FAIL same_cycle_bdrop: got bvalid=%b want 0", S_BVALID); end
    do_read(32'h04, d, r, tmo);
    total++;
    if (tmo || d !== 32'hDEADBEEF || r !== 2'b00) begin
      bad++; $display("FAIL same_cycle_read: got %h/%b want deadbeef/00", d, r);
    end
  endtask

  task automatic test_w_before_aw();
    logic [1:0] r;
    int         lat;
    bit         tmo;
    do_write(32'h08, 32'hAABBCCDD, 4'hF, 0, 0, r, lat, tmo);
    m_write(32'h08, 32'hAABBCCDD, 4'hF);
    do_write(32'h08, 32'h11223344, 4'b0101, 3, 0, r, lat, tmo);
    m_write(32'h08, 32'h11223344, 4'b0101);
    total++;
    if (tmo || lat != 1 || r !== 2'b00) begin
      bad++; $display("FAIL w_first_b: got lat=%0d resp=%b tmo=%0d want lat=1 resp=00", lat, r, tmo);
    end
    total++;
    if (regs_out[2*DW +: DW] !== 32'hAA22CC44) begin
      bad++; $display("FAIL w_first_strb: got %h want aa22cc44", regs_out[2*DW +: DW]);
    end
    total++;
    if (regs_out !== m_flat()) begin bad++; $display("FAIL w_first_regs: got %h want %h", regs_out, m_flat()); end
  endtask

  task automatic test_errors();
    logic [31:0] d;
    logic [1:0]  r;
    int          lat;
    bit          tmo;
    do_write(32'h40, 32'h12345678, 4'hF, 0, 1, r, lat, tmo);
    total++;
    if (tmo || r !== 2'b10 || regs_out !== m_flat()) begin
      bad++; $display("FAIL err_write_range: got resp=%b tmo=%0d regs=%h want resp=10 regs=%h", r, tmo, regs_out, m_flat());
    end
    do_write(32'h14, 32'h87654321, 4'hF, 1, 0, r, lat, tmo);
    total++;
    if (tmo || r !== 2'b10 || regs_out !== m_flat()) begin
      bad++; $display("FAIL err_write_ro: got resp=%b tmo=%0d regs=%h want resp=10 regs=%h", r, tmo, regs_out, m_flat());
    end
    do_read(32'h40, d, r, tmo);
    total++;
    if (tmo || d !== 32'h0 || r !== 2'b10) begin bad++; $display("FAIL err_read_range: got %h/%b want 0/10", d, r); end
    do_read(32'h14, d, r, tmo);
    total++;
    if (tmo || d !== RST_VAL || r !== 2'b00) begin bad++; $display("FAIL ro_read: got %h/%b want %h/00", d, r, RST_VAL); end
    do_read(32'h0B, d, r, tmo);
    total++;
    if (tmo || d !== m_read(32'h08) || r !== 2'b00) begin
      bad++; $display("FAIL unaligned_read: got %h/%b want %h/00", d, r, m_read(32'h08));
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d1;
    logic [31:0] d2;
    logic [31:0] old3;
    logic [31:0] old4;
    logic [1:0]  r;
    int          lat;
    bit          tmo;
    bit          ok;
    d1 = $urandom;
    d2 = $urandom;
    old3 = m_read(32'h0C);
    old4 = m_read(32'h10);
    S_BREADY = 0; S_RREADY = 0;
    S_AWADDR = 32'h0C; S_AWVALID = 1; S_WDATA = d1; S_WSTRB = 4'hF; S_WVALID = 1;
    @(posedge clk);
    @(negedge clk);
    S_AWVALID = 0; S_WVALID = 0;
    m_write(32'h0C, d1, 4'hF);
    // AR lands on the commit edge of the same register
    S_ARADDR = 32'h0C; S_ARVALID = 1;
    @(posedge clk);
    @(negedge clk);
    S_ARVALID = 0;
    total++;
    if (S_BVALID !== 1 || S_BRESP !== 2'b00 || S_RVALID !== 1 || S_RDATA !== old3 || S_RRESP !== 2'b00) begin
      bad++; $display("FAIL commit_edge_read: got bv=%b br=%b rv=%b rd=%h rr=%b want 1/00/1/%h/00",
                      S_BVALID, S_BRESP, S_RVALID, S_RDATA, S_RRESP, old3);
    end
    S_AWADDR = 32'h10; S_AWVALID = 1; S_WDATA = d2; S_WSTRB = 4'hF; S_WVALID = 1;
    S_ARADDR = 32'h10; S_ARVALID = 1;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (S_BVALID !== 1 || S_BRESP !== 2'b00 || S_RVALID !== 1 || S_RDATA !== old3 || S_RRESP !== 2'b00 ||
          S_AWREADY !== 0 || S_WREADY !== 0 || S_ARREADY !== 0) ok = 0;
    end
    total++;
    if (!ok) begin
      bad++; $display("FAIL stall_hold: got bv=%b rv=%b rd=%h awr=%b wr=%b arr=%b want 1 1 %h 0 0 0",
                      S_BVALID, S_RVALID, S_RDATA, S_AWREADY, S_WREADY, S_ARREADY, old3);
    end
    S_BREADY = 1; S_RREADY = 1;
    @(posedge clk);
    @(negedge clk);
    S_BREADY = 0; S_RREADY = 0;
    total++;
    if ({S_BVALID, S_RVALID, S_AWREADY, S_WREADY, S_ARREADY} !== 5'b00111) begin
      bad++; $display("FAIL release: got bv,rv,awr,wr,arr=%b want 00111", {S_BVALID, S_RVALID, S_AWREADY, S_WREADY, S_ARREADY});
    end
    @(posedge clk);
    @(negedge clk);
    S_AWVALID = 0; S_WVALID = 0; S_ARVALID = 0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (S_BVALID !== 1 || S_BRESP !== 2'b00 || S_RVALID !== 1 || S_RDATA !== old4) begin
      bad++; $display("FAIL after_release: got bv=%b br=%b rv=%b rd=%h want 1/00/1/%h", S_BVALID, S_BRESP, S_RVALID, S_RDATA, old4);
    end
    m_write(32'h10, d2, 4'hF);
    S_BREADY = 1; S_RREADY = 1;
    @(posedge clk);
    @(negedge clk);
    S_BREADY = 0; S_RREADY = 0;
    total++;
    if (regs_out !== m_flat()) begin bad++; $display("FAIL backpressure_regs: got %h want %h", regs_out, m_flat()); end
    do_write(32'h0C, 32'h0, 4'h0, 0, 0, r, lat, tmo);
    total++;
    if (tmo || r !== 2'b00 || regs_out !== m_flat()) begin
      bad++; $display("FAIL zero_strb: got resp=%b tmo=%0d regs=%h want 00 regs=%h", r, tmo, regs_out, m_flat());
    end
  endtask

  task automatic test_reset_midflight();
    logic [1:0] r;
    int         lat;
    bit         tmo;
    bit         seen_b;
    S_AWADDR = 32'h18; S_AWVALID = 1;
    @(posedge clk);
    @(negedge clk);
    S_AWVALID = 0;
    rst = 1'b1;
    m_reset();
    @(negedge clk);
    total++;
    if (regs_out !== m_flat() || S_BVALID !== 0) begin
      bad++; $display("FAIL midflight_reset: got bv=%b regs=%h want 0 regs=%h", S_BVALID, regs_out, m_flat());
    end
    rst = 1'b0;
    seen_b = 0;
    repeat (4) begin
      @(negedge clk);
      if (S_BVALID !== 0) seen_b = 1;
    end
    total++;
    if (seen_b) begin bad++; $display("FAIL midflight_no_b: got bvalid=1 want 0"); end
    do_write(32'h1C, 32'h5566_7788, 4'hF, 4, 0, r, lat, tmo);
    m_write(32'h1C, 32'h5566_7788, 4'hF);
    total++;
    if (tmo || lat != 1 || r !== 2'b00 || regs_out !== m_flat()) begin
      bad++; $display("FAIL midflight_next: got lat=%0d resp=%b regs=%h want 1/00 regs=%h", lat, r, regs_out, m_flat());
    end
  endtask

  task automatic test_random();
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] got;
    logic [31:0] want;
    logic [1:0]  r;
    int          lat;
    bit          tmo;
    for (int n = 0; n < 60; n++) begin
      a = ($urandom_range(0, 19) * 4) + $urandom_range(0, 3);
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, $urandom_range(0, 3), $urandom_range(0, 3), r, lat, tmo);
        m_write(a, d, s);
        total++;
        if (tmo || lat != 1 || r !== m_resp(a, 1'b1) || regs_out !== m_flat()) begin
          bad++; $display("FAIL rand_write a=%h: got lat=%0d resp=%b tmo=%0d want lat=1 resp=%b", a, lat, r, tmo, m_resp(a, 1'b1));
        end
      end else begin
        exp_q.push_back(m_read(a));
        do_read(a, got, r, tmo);
        want = exp_q.pop_front();
        total++;
        if (tmo || got !== want || r !== m_resp(a, 1'b0)) begin
          bad++; $display("FAIL rand_read a=%h: got %h/%b tmo=%0d want %h/%b", a, got, r, tmo, want, m_resp(a, 1'b0));
        end
      end
    end
  endtask

  initial begin
    ro_bits = RO_MASK;
    rst = 1'b1;
    @(negedge clk);
    test_reset();
    test_same_cycle();
    test_w_before_aw();
    test_errors();
    test_backpressure();
    test_reset_midflight();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
